intersection_scheduler: RTL

//  Sequences a two-road intersection (NS / EW) that shares one crossing area.

---
 rtl/intersection_scheduler_pkg.sv | 42 ++++
 rtl/intersection_scheduler_if.sv | 29 ++
 rtl/intersection_scheduler_phase_timer.sv | 30 +++
 rtl/intersection_scheduler.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/intersection_scheduler_pkg.sv
// Shared definitions for the two-road intersection scheduler: phase codes,
// lamp bit positions and default phase durations.
package intersection_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StNsG  = 3'd1,
    StNsY  = 3'd2,
    StAr1  = 3'd3,
    StEwG  = 3'd4,
    StEwY  = 3'd5,
    StAr2  = 3'd6
  } phase_e;

  // Lamp vector bit positions, shared with traffic_fsm.
  localparam int unsigned LampG = 0;
  localparam int unsigned LampY = 1;
  localparam int unsigned LampR = 2;

  localparam int unsigned DefLightStateWidth = 3;
  localparam int unsigned DefCntW            = 8;
  localparam int unsigned DefGreenTime       = 10;
  localparam int unsigned DefYellowTime      = 3;
  localparam int unsigned DefAllredTime      = 2;
  localparam int unsigned DefWalkTime        = 6;

  function automatic phase_e next_phase(input phase_e cur);
    phase_e nxt;
    case (cur)
      StIdle:  nxt = StNsG;
      StNsG:   nxt = StNsY;
      StNsY:   nxt = StAr1;
      StAr1:   nxt = StEwG;
      StEwG:   nxt = StEwY;
      StEwY:   nxt = StAr2;
      StAr2:   nxt = StNsG;
      default: nxt = StIdle;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/intersection_scheduler_if.sv
// Control/status bundle between the intersection scheduler and its controller:
// run enable, time base, pedestrian requests in; lamps, walks and phase out.
interface intersection_scheduler_if #(
  parameter int unsigned LIGHT_STATE_WIDTH = 3,
  parameter int unsigned CNT_W             = 8
);

  logic                         en;
  logic                         tick;
  logic                         ped_req_ns;
  logic                         ped_req_ew;
  logic [LIGHT_STATE_WIDTH-1:0] light_ns;
  logic [LIGHT_STATE_WIDTH-1:0] light_ew;
  logic                         walk_ns;
  logic                         walk_ew;
  logic [2:0]                   phase;
  logic [CNT_W-1:0]             remaining;

  modport master (
    output en, tick, ped_req_ns, ped_req_ew,
    input  light_ns, light_ew, walk_ns, walk_ew, phase, remaining
  );

  modport slave (
    input  en, tick, ped_req_ns, ped_req_ew,
    output light_ns, light_ew, walk_ns, walk_ew, phase, remaining
  );

endinterface

// File: rtl/intersection_scheduler_phase_timer.sv
// Loadable down-counter for phase durations. Load wins over tick; a tick at
// zero leaves the count at zero so the scheduler can see the expiry.
module intersection_scheduler_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] value_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= load_val;
    end else if (tick && (value_q != '0)) begin
      value_q <= value_q - CNT_W'(1);
    end
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

// File: rtl/intersection_scheduler.sv
// Two-road intersection phase sequencer: owns phase order, all-red clearance
// and pedestrian walk grants; lamp and walk outputs decode registered state.
module intersection_scheduler
  import intersection_scheduler_pkg::*;
#(
  parameter int unsigned LIGHT_STATE_WIDTH = DefLightStateWidth,
  parameter int unsigned CNT_W             = DefCntW,
  parameter int unsigned GREEN_TIME        = DefGreenTime,
  parameter int unsigned YELLOW_TIME       = DefYellowTime,
  parameter int unsigned ALLRED_TIME       = DefAllredTime,
  parameter int unsigned WALK_TIME         = DefWalkTime
) (
  input logic                  clk,
  input logic                  rst_n,
  intersection_scheduler_if.slave bus
);

  // Walk is shown while the green counter is still at or above this value.
  localparam logic [CNT_W-1:0] WalkThresh = CNT_W'(GREEN_TIME - WALK_TIME);
  localparam logic [CNT_W-1:0] GreenLoad  = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] YellowLoad = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AllredLoad = CNT_W'(ALLRED_TIME - 1);

  phase_e           state_q;
  phase_e           next_state;
  logic             grant_ns_q;
  logic             grant_ew_q;
  logic             pend_ns_q;
  logic             pend_ew_q;
  logic             enter;
  logic             tmr_load;
  logic             tmr_zero;
  logic [CNT_W-1:0] tmr_load_val;
  logic [CNT_W-1:0] tmr_value;

  logic [LIGHT_STATE_WIDTH-1:0] lamp_ns;
  logic [LIGHT_STATE_WIDTH-1:0] lamp_ew;

  assign next_state = next_phase(state_q);
  assign enter      = bus.en & ((state_q == StIdle) | (bus.tick & tmr_zero));

  // Dropping en reloads the counter with zero so IDLE always reports 0.
  always_comb begin
    tmr_load     = ~bus.en | enter;
    tmr_load_val = '0;
    if (bus.en) begin
      case (next_state)
        StNsG, StEwG: tmr_load_val = GreenLoad;
        StNsY, StEwY: tmr_load_val = YellowLoad;
        StAr1, StAr2: tmr_load_val = AllredLoad;
        default:      tmr_load_val = '0;
      endcase
    end
  end

  intersection_scheduler_phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .tick     (bus.tick),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      grant_ns_q <= 1'b0;
      grant_ew_q <= 1'b0;
      pend_ns_q  <= 1'b0;
      pend_ew_q  <= 1'b0;
    end else begin
      pend_ns_q <= pend_ns_q | bus.ped_req_ns;
      pend_ew_q <= pend_ew_q | bus.ped_req_ew;
      if (!bus.en) begin
        state_q    <= StIdle;
        grant_ns_q <= 1'b0;
        grant_ew_q <= 1'b0;
      end else if (enter) begin
        state_q <= next_state;
        // A request on the entry edge itself is folded into the grant.
        if (next_state == StNsG) begin
          grant_ns_q <= pend_ns_q | bus.ped_req_ns;
          pend_ns_q  <= 1'b0;
        end
        if (next_state == StEwG) begin
          grant_ew_q <= pend_ew_q | bus.ped_req_ew;
          pend_ew_q  <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    lamp_ns = '0;
    lamp_ew = '0;
    case (state_q)
      StNsG: begin
        lamp_ns[LampG] = 1'b1;
        lamp_ew[LampR] = 1'b1;
      end
      StNsY: begin
        lamp_ns[LampY] = 1'b1;
        lamp_ew[LampR] = 1'b1;
      end
      StAr1, StAr2: begin
        lamp_ns[LampR] = 1'b1;
        lamp_ew[LampR] = 1'b1;
      end
      StEwG: begin
        lamp_ns[LampR] = 1'b1;
        lamp_ew[LampG] = 1'b1;
      end
      StEwY: begin
        lamp_ns[LampR] = 1'b1;
        lamp_ew[LampY] = 1'b1;
      end
      default: begin
        lamp_ns = '0;
        lamp_ew = '0;
      end
    endcase
  end

  assign bus.light_ns  = lamp_ns;
  assign bus.light_ew  = lamp_ew;
  assign bus.walk_ns   = (state_q == StNsG) & grant_ns_q & (tmr_value >= WalkThresh);
  assign bus.walk_ew   = (state_q == StEwG) & grant_ew_q & (tmr_value >= WalkThresh);
  assign bus.phase     = state_q;
  assign bus.remaining = tmr_value;

  // Conflicting movements must never be released together.
  a_no_conflict: assert property (@(posedge clk) disable iff (!rst_n)
    !((lamp_ns[LampG] | lamp_ns[LampY]) & (lamp_ew[LampG] | lamp_ew[LampY])));
  a_walk_ns_green: assert property (@(posedge clk) disable iff (!rst_n)
    bus.walk_ns |-> lamp_ns[LampG]);
  a_walk_ew_green: assert property (@(posedge clk) disable iff (!rst_n)
    bus.walk_ew |-> lamp_ew[LampG]);

endmodule
